muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter WIDTH, default 32, operand and HI/LO register width.
REQ-002 Parameter MUL_CYCLES, default 5, busy cycles for multiply-class ops; legal range 1..63.
REQ-003 Parameter DIV_CYCLES, default 10, busy cycles for divide-class ops; legal range 1..63.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  one clock; reset is synchronous and active-low.
REQ-006 start  input  1  op request, sampled on rising edge.
REQ-007 op  input  4  operation code (package enum).
REQ-008 a  input  WIDTH  operand A (rs value).
REQ-009 b  input  WIDTH  operand B (rt value).
REQ-010 flush  input  1  cancel in-flight op (pipeline clear).
REQ-011 busy  output  1  op in progress; pipeline stalls HI/LO consumers and new MD ops.
REQ-012 done  output  1  one-cycle pulse, cycle after a result commit.
REQ-013 hi  output  WIDTH  architectural HI register.
REQ-014 lo  output  WIDTH  architectural LO register.

Function
REQ-015 Ops: MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI, MTLO; other codes with start=1 SHALL be ignored.
REQ-016 States: IDLE, RUN; IDLE->RUN on start with a multi-cycle op; RUN->IDLE on counter expiry or flush.
REQ-017 On accept, operands SHALL be latched and the full 2*WIDTH result computed into a pending register; later a/b changes SHALL have no effect.
REQ-018 busy SHALL rise the cycle after accept and stay high exactly MUL_CYCLES or DIV_CYCLES cycles.
REQ-019 hi/lo SHALL update on the edge where busy falls; done SHALL pulse high the following cycle.
REQ-020 MULT/MULTU: {hi,lo} = a*b, signed/unsigned, 2*WIDTH bits.
REQ-021 MADD(U)/MSUB(U): {hi,lo} = {hi,lo} +/- a*b, modulo 2^(2*WIDTH), using hi/lo values at commit time.
REQ-022 DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with sign of dividend.
REQ-023 Divide by zero: lo = all ones, hi = a; no trap.
REQ-024 Signed overflow (most-negative / -1): lo = a, hi = 0.
REQ-025 MTHI/MTLO: write a into hi/lo on the accept edge; busy SHALL stay low; done SHALL NOT pulse.
REQ-026 start while busy SHALL be ignored (no queueing); the in-flight op is unaffected.
REQ-027 flush in RUN: op discarded, hi/lo keep pre-op values, busy low next cycle, no done.
REQ-028 flush and start in the same cycle: flush wins; start SHALL be ignored.
REQ-029 flush in the commit cycle (last busy cycle) SHALL still discard the result.
REQ-030 No combinational path from start/op/a/b to busy.

Reset
REQ-031 When reset=0 at a rising edge: state IDLE, counter 0, busy 0, done 0, hi 0, lo 0, pending result 0.
REQ-032 Reset mid-operation SHALL abort the op with no commit and no done pulse.
REQ-033 Reset SHALL take priority over start and flush.

Structure
REQ-034 Shared package holds the op enum (4-bit), the state enum, and the is_mul/is_div/is_acc classification helpers.
REQ-035 One sub-module, md_divider: combinational signed/unsigned divide with REQ-023/REQ-024 corner handling; the multiply stays inline.
REQ-036 Counter width SHALL be 6 bits, sized for the 63-cycle limit.

Verification
REQ-037 WIDTH=32; MULT a=0xFFFFFFFF, b=2 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE, done pulse.
REQ-038 DIVU a=7, b=0 -> busy 10 cycles; lo=0xFFFFFFFF, hi=7; DIV a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-039 MTHI a=5, then MADDU a=3, b=4 -> hi=5 immediately, busy low; final {hi,lo}={5,12}.
REQ-040 DIV a=-7, b=2; flush on busy cycle 10 -> hi/lo unchanged, no done; repeat without flush -> lo=-3, hi=-1.
REQ-041 start MULT while busy on a DIV -> second op ignored; only DIV result commits, after exactly 10 cycles.
REQ-042 reset=0 on busy cycle 3 of MULT -> busy 0, hi=lo=0 next cycle, no done.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide unit.
//   md_op_e    : 4-bit operation code driven on the op port
//   md_state_e : control FSM states
//   cnt_t      : busy-cycle counter type (6 bits, covers up to 63 cycles)
//   is_mul / is_div / is_acc / is_sub / is_signed_op : op classification helpers
package muldiv_unit_pkg;

  localparam int unsigned CntWidth = 6;
  typedef logic [CntWidth-1:0] cnt_t;

  typedef enum logic [3:0] {
    OpMult  = 4'd0,
    OpMultu = 4'd1,
    OpDiv   = 4'd2,
    OpDivu  = 4'd3,
    OpMadd  = 4'd4,
    OpMaddu = 4'd5,
    OpMsub  = 4'd6,
    OpMsubu = 4'd7,
    OpMthi  = 4'd8,
    OpMtlo  = 4'd9
  } md_op_e;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } md_state_e;

  // Multiply-class: anything that goes through the multiplier, including accumulates.
  function automatic logic is_mul(logic [3:0] op);
    return op inside {OpMult, OpMultu, OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic is_div(logic [3:0] op);
    return op inside {OpDiv, OpDivu};
  endfunction

  // Accumulating ops combine the product with HI/LO at commit time.
  function automatic logic is_acc(logic [3:0] op);
    return op inside {OpMadd, OpMaddu, OpMsub, OpMsubu};
  endfunction

  function automatic logic is_sub(logic [3:0] op);
    return op inside {OpMsub, OpMsubu};
  endfunction

  function automatic logic is_signed_op(logic [3:0] op);
    return op inside {OpMult, OpDiv, OpMadd, OpMsub};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
//   start, op, a, b, flush : request side (master drives)
//   busy, done, hi, lo     : status and architectural HI/LO (slave drives)
interface muldiv_unit_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/md_divider.sv
// Combinational signed/unsigned divider.
//   dividend_i, divisor_i : operands
//   is_signed_i           : treat operands as two's complement
//   quotient_o            : truncated toward zero
//   remainder_o           : carries the sign of the dividend
// Divide by zero returns quotient all ones and remainder = dividend.
// Most-negative / -1 returns quotient = dividend and remainder 0.
module md_divider #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             is_signed_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_a;
  logic             neg_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  always_comb begin
    neg_a = is_signed_i & dividend_i[WIDTH-1];
    neg_b = is_signed_i & divisor_i[WIDTH-1];
    // Negating MinNeg yields MinNeg, which is the correct unsigned magnitude.
    mag_a = neg_a ? -dividend_i : dividend_i;
    mag_b = neg_b ? -divisor_i : divisor_i;
    uq    = '0;
    ur    = '0;
    if (mag_b != '0) begin
      uq = mag_a / mag_b;
      ur = mag_a % mag_b;
    end
    quotient_o  = (neg_a ^ neg_b) ? -uq : uq;
    remainder_o = neg_a ? -ur : ur;

    if (divisor_i == '0) begin
      quotient_o  = '1;
      remainder_o = dividend_i;
    end else if (is_signed_i && (dividend_i == MinNeg) && (divisor_i == '1)) begin
      quotient_o  = dividend_i;
      remainder_o = '0;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-low reset
//   md    : slave side of muldiv_unit_if (start/op/a/b/flush in, busy/done/hi/lo out)
// The result is computed at accept time into a pending register; the FSM only
// counts busy cycles and commits (or discards on flush) when the count expires.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic           clk,
  input logic           reset,
  muldiv_unit_if.slave  md
);

  localparam int unsigned W2 = 2 * WIDTH;

  md_state_e        state_q;
  cnt_t             cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [W2-1:0]    pending_q;
  logic [3:0]       op_q;

  logic             op_signed;
  logic [W2-1:0]    ext_a;
  logic [W2-1:0]    ext_b;
  logic [W2-1:0]    product;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [W2-1:0]    hilo;
  logic [W2-1:0]    commit_val;
  logic             start_ok;

  // Extending operands to 2*WIDTH lets one multiplier serve both signednesses.
  always_comb begin
    op_signed = is_signed_op(md.op);
    ext_a     = op_signed ? {{WIDTH{md.a[WIDTH-1]}}, md.a} : {{WIDTH{1'b0}}, md.a};
    ext_b     = op_signed ? {{WIDTH{md.b[WIDTH-1]}}, md.b} : {{WIDTH{1'b0}}, md.b};
    product   = ext_a * ext_b;
  end

  md_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .dividend_i  (md.a),
    .divisor_i   (md.b),
    .is_signed_i (op_signed),
    .quotient_o  (quo),
    .remainder_o (rem)
  );

  // Accumulates use HI/LO as they stand at commit, not at accept.
  always_comb begin
    hilo       = {hi_q, lo_q};
    commit_val = pending_q;
    if (is_acc(op_q)) begin
      commit_val = is_sub(op_q) ? (hilo - pending_q) : (hilo + pending_q);
    end
  end

  // Flush blocks acceptance in the same cycle.
  assign start_ok = md.start & ~md.flush & (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pending_q <= '0;
      op_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start_ok) begin
            if (is_mul(md.op) || is_div(md.op)) begin
              state_q   <= StRun;
              busy_q    <= 1'b1;
              op_q      <= md.op;
              cnt_q     <= is_div(md.op) ? cnt_t'(DIV_CYCLES) : cnt_t'(MUL_CYCLES);
              pending_q <= is_div(md.op) ? {rem, quo} : product;
            end else if (md.op == OpMthi) begin
              hi_q <= md.a;
            end else if (md.op == OpMtlo) begin
              lo_q <= md.a;
            end
          end
        end
        StRun: begin
          if (md.flush) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == cnt_t'(1)) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b1;
            hi_q    <= commit_val[W2-1:WIDTH];
            lo_q    <= commit_val[WIDTH-1:0];
          end else begin
            cnt_q <= cnt_q - cnt_t'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.done = done_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  muldiv_unit_if #(.WIDTH(32)) mif ();

  muldiv_unit #(
    .WIDTH      (32),
    .MUL_CYCLES (5),
    .DIV_CYCLES (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; returns in the first cycle after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.start = 1'b1;
    mif.op    = op;
    mif.a     = a;
    mif.b     = b;
    tick();
    mif.start = 1'b0;
  endtask

  // Counts busy cycles from now until busy drops, bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (mif.busy && n < 70) begin
      n++;
      tick();
    end
  endtask

  int n;

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    mif.start = 1'b0;
    mif.flush = 1'b0;
    mif.op    = 4'd0;
    mif.a     = '0;
    mif.b     = '0;

    // Reset state
    tick();
    tick();
    check("rst_busy", {31'd0, mif.busy}, 32'd0);
    check("rst_done", {31'd0, mif.done}, 32'd0);
    check("rst_hi", mif.hi, 32'd0);
    check("rst_lo", mif.lo, 32'd0);
    reset = 1'b1;
    tick();

    // MULT -1 * 2, operands changed after accept
    issue(OpMult, 32'hFFFF_FFFF, 32'd2);
    mif.a = 32'd0;
    mif.b = 32'd0;
    check("mult_busy_rise", {31'd0, mif.busy}, 32'd1);
    wait_idle(n);
    check("mult_cycles", n, 32'd5);
    check("mult_done", {31'd0, mif.done}, 32'd1);
    check("mult_hi", mif.hi, 32'hFFFF_FFFF);
    check("mult_lo", mif.lo, 32'hFFFF_FFFE);
    tick();
    check("mult_done_once", {31'd0, mif.done}, 32'd0);

    // MULTU 0xFFFFFFFF * 2
    issue(OpMultu, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_cycles", n, 32'd5);
    check("multu_hi", mif.hi, 32'd1);
    check("multu_lo", mif.lo, 32'hFFFF_FFFE);

    // DIVU by zero
    issue(OpDivu, 32'd7, 32'd0);
    wait_idle(n);
    check("divu0_cycles", n, 32'd10);
    check("divu0_done", {31'd0, mif.done}, 32'd1);
    check("divu0_lo", mif.lo, 32'hFFFF_FFFF);
    check("divu0_hi", mif.hi, 32'd7);

    // DIV signed overflow
    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("divovf_lo", mif.lo, 32'h8000_0000);
    check("divovf_hi", mif.hi, 32'd0);
    tick();

    // MTLO 0, MTHI 5, MADDU 3*4
    issue(OpMtlo, 32'd0, 32'd0);
    check("mtlo_lo", mif.lo, 32'd0);
    issue(OpMthi, 32'd5, 32'd0);
    check("mthi_hi", mif.hi, 32'd5);
    check("mthi_busy", {31'd0, mif.busy}, 32'd0);
    tick();
    check("mthi_nodone", {31'd0, mif.done}, 32'd0);
    issue(OpMaddu, 32'd3, 32'd4);
    wait_idle(n);
    check("maddu_cycles", n, 32'd5);
    check("maddu_hi", mif.hi, 32'd5);
    check("maddu_lo", mif.lo, 32'd12);

    // MSUB 2*7: {5,12} - 14 = {4, 0xFFFFFFFE}
    issue(OpMsub, 32'd2, 32'd7);
    wait_idle(n);
    check("msub_hi", mif.hi, 32'd4);
    check("msub_lo", mif.lo, 32'hFFFF_FFFE);
    tick();

    // DIV -7/2 flushed on the last busy cycle
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < 9; i++) tick();
    check("flush_still_busy", {31'd0, mif.busy}, 32'd1);
    mif.flush = 1'b1;
    tick();
    mif.flush = 1'b0;
    check("flush_busy", {31'd0, mif.busy}, 32'd0);
    check("flush_done", {31'd0, mif.done}, 32'd0);
    check("flush_hi", mif.hi, 32'd4);
    check("flush_lo", mif.lo, 32'hFFFF_FFFE);
    tick();
    check("flush_done_late", {31'd0, mif.done}, 32'd0);

    // flush and start together: start ignored
    mif.flush = 1'b1;
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    mif.flush = 1'b0;
    check("flush_start_busy", {31'd0, mif.busy}, 32'd0);

    // DIV -7/2 without flush
    issue(OpDiv, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_cycles", n, 32'd10);
    check("div_lo", mif.lo, 32'hFFFF_FFFD);
    check("div_hi", mif.hi, 32'hFFFF_FFFF);
    tick();

    // MULT requested while DIVU 100/7 is busy
    issue(OpDivu, 32'd100, 32'd7);
    tick();
    tick();
    mif.start = 1'b1;
    mif.op    = OpMult;
    mif.a     = 32'd3;
    mif.b     = 32'd3;
    tick();
    mif.start = 1'b0;
    wait_idle(n);
    check("busy_start_cycles", n, 32'd7);
    check("busy_start_done", {31'd0, mif.done}, 32'd1);
    check("busy_start_lo", mif.lo, 32'd14);
    check("busy_start_hi", mif.hi, 32'd2);
    tick();
    check("busy_start_idle", {31'd0, mif.busy}, 32'd0);

    // Reset on busy cycle 3 of MULT
    issue(OpMult, 32'd3, 32'd3);
    tick();
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_busy", {31'd0, mif.busy}, 32'd0);
    check("midrst_hi", mif.hi, 32'd0);
    check("midrst_lo", mif.lo, 32'd0);
    check("midrst_done", {31'd0, mif.done}, 32'd0);
    for (int i = 0; i < 6; i++) tick();
    check("midrst_done_late", {31'd0, mif.done}, 32'd0);
    check("midrst_lo_late", mif.lo, 32'd0);

    // Reset beats start
    reset = 1'b0;
    issue(OpMthi, 32'd9, 32'd0);
    reset = 1'b1;
    check("rst_over_start", mif.hi, 32'd0);

    // Undefined op code ignored
    issue(4'hF, 32'd1, 32'd1);
    check("badop_busy", {31'd0, mif.busy}, 32'd0);
    check("badop_hi", mif.hi, 32'd0);
    check("badop_lo", mif.lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
